// File: rtl/data_mem_responder_if.sv
// Load/store port between the core and the data-memory responder.
// Request: req_valid/req_ready handshake carrying we, funct3, addr, wdata.
// Response: rsp_valid/rsp_ready handshake carrying rdata and err.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Core side.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: RV32I byte/half/word loads and stores into local byte storage.
// Latency: rsp_valid rises LATENCY cycles after the accept edge; next accept no sooner than LATENCY+1.
// Backpressure: one transaction in flight; response held stable while rsp_ready=0, req_ready=0 outside IDLE.
// Ports: clk, rst (async, active-low), bus (slave modport: req_* in, rsp_* out).
module data_mem_responder #(
  parameter int unsigned ADDRESS_WIDTH = 17,            // must be 2..31
  parameter int unsigned DATA_WIDTH    = 32,            // only 32 supported
  parameter int unsigned LATENCY       = 2,             // 1..15
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned MEM_BYTES = 1 << ADDRESS_WIDTH;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    we_q, we_d;
  logic [2:0]              f3_q, f3_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [7:0] mem [MEM_BYTES];

  // The operation being decoded: live inputs in IDLE (needed for LATENCY=1,
  // where commit happens on the accept edge), latched copy afterwards.
  logic                     op_we;
  logic [2:0]               op_f3;
  logic [31:0]              op_addr, op_wdata, offset;
  logic                     range_err, f3_err, align_err, op_err;
  logic [ADDRESS_WIDTH-1:0] mem_idx;
  logic [ADDRESS_WIDTH-1:0] byte_idx [4];
  logic [1:0]               lane;
  logic [31:0]              rd_word, rd_shift, load_data, wr_lanes;
  logic [3:0]               wr_be;
  logic                     accept, commit;

  assign op_we    = (state_q == IDLE) ? bus.req_we     : we_q;
  assign op_f3    = (state_q == IDLE) ? bus.req_funct3 : f3_q;
  assign op_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
  assign op_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;

  // Unsigned subtract: addresses below BASE_ADDR wrap to huge offsets and
  // fall into the range check as well.
  assign offset    = op_addr - BASE_ADDR;
  assign range_err = |offset[31:ADDRESS_WIDTH];
  assign f3_err    = op_we ? !(op_f3 inside {3'b000, 3'b001, 3'b010})
                           : !(op_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign align_err = ((op_f3[1:0] == 2'b01) && offset[0]) ||
                     ((op_f3[1:0] == 2'b10) && (offset[1:0] != 2'b00));
  assign op_err    = range_err | f3_err | align_err;

  assign mem_idx = offset[ADDRESS_WIDTH-1:0];
  assign lane    = mem_idx[1:0];

  // Access is always done on the containing aligned word, then lanes are picked.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_idx[i]      = {mem_idx[ADDRESS_WIDTH-1:2], 2'(i)};
      rd_word[8*i +: 8] = mem[byte_idx[i]];
    end
  end

  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = '0;
    case (op_f3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b101:  load_data = {16'h0, rd_shift[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = op_wdata;
    case (op_f3[1:0])
      2'b00: begin
        wr_be    = 4'b0001 << lane;
        wr_lanes = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{op_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // ready_q is only ever 1 in IDLE, so it alone qualifies the accept.
  assign accept = bus.req_valid & ready_q;
  // Edge entering RESP: commit stores and sample loads here.
  assign commit = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      valid_d = 1'b1;
      err_d   = op_err;
      rdata_d = (op_we || op_err) ? '0 : load_data;
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[byte_idx[i]] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for function/errors/backpressure,
// LATENCY=3 instance for reset-during-transaction.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst3;
  data_mem_responder_if bif2();
  data_mem_responder_if bif3();

  data_mem_responder #(.ADDRESS_WIDTH(17), .DATA_WIDTH(32), .LATENCY(2), .BASE_ADDR(32'h0001_0000))
    dut2 (.clk(clk), .rst(rst), .bus(bif2.slave));
  data_mem_responder #(.ADDRESS_WIDTH(17), .DATA_WIDTH(32), .LATENCY(3), .BASE_ADDR(32'h0001_0000))
    dut3 (.clk(clk), .rst(rst3), .bus(bif3.slave));

  // Common drive signals; sel routes the handshake to dut2 (0) or dut3 (1).
  logic        sel, d_valid, d_we, d_rsp_ready;
  logic [2:0]  d_f3;
  logic [31:0] d_addr, d_wdata;

  assign bif2.req_valid  = d_valid & ~sel;
  assign bif3.req_valid  = d_valid & sel;
  assign bif2.rsp_ready  = d_rsp_ready & ~sel;
  assign bif3.rsp_ready  = d_rsp_ready & sel;
  assign bif2.req_we     = d_we;
  assign bif3.req_we     = d_we;
  assign bif2.req_funct3 = d_f3;
  assign bif3.req_funct3 = d_f3;
  assign bif2.req_addr   = d_addr;
  assign bif3.req_addr   = d_addr;
  assign bif2.req_wdata  = d_wdata;
  assign bif3.req_wdata  = d_wdata;

  wire        o_req_ready = sel ? bif3.req_ready : bif2.req_ready;
  wire        o_rsp_valid = sel ? bif3.rsp_valid : bif2.rsp_valid;
  wire [31:0] o_rsp_rdata = sel ? bif3.rsp_rdata : bif2.rsp_rdata;
  wire        o_rsp_err   = sel ? bif3.rsp_err   : bif2.rsp_err;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request and step past its accept edge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    d_valid = 1'b1; d_we = we; d_f3 = f3; d_addr = addr; d_wdata = wdata;
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  // Cycles from accept to rsp_valid; 1 means visible right after the accept edge.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    d_rsp_ready = 1'b1;
    @(posedge clk); #1;
    d_rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    chk({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    send(we, f3, addr, wdata);
    wait_rsp(lat);
    chk({tag, "_latency"}, 32'(lat), sel ? 32'd3 : 32'd2);
    chk({tag, "_rdata"}, o_rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
    ack();
    chk({tag, "_valid_clr"}, 32'(o_rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    sel = 1'b0; rst = 1'b0; rst3 = 1'b0;
    d_valid = 1'b0; d_we = 1'b0; d_f3 = 3'b000; d_addr = '0; d_wdata = '0; d_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    rst = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 32'(o_req_ready), 32'd1);

    // Word store/load and sub-word loads
    txn("sw_base",  1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn("lw_base",  1'b0, 3'b010, 32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 1'b0);
    txn("lb_3",     1'b0, 3'b000, 32'h0001_0003, 32'h0,         32'hFFFF_FFDE, 1'b0);
    txn("lbu_3",    1'b0, 3'b100, 32'h0001_0003, 32'h0,         32'h0000_00DE, 1'b0);
    txn("lh_0",     1'b0, 3'b001, 32'h0001_0000, 32'h0,         32'hFFFF_BEEF, 1'b0);
    txn("lhu_2",    1'b0, 3'b101, 32'h0001_0002, 32'h0,         32'h0000_DEAD, 1'b0);

    // Sub-word stores
    txn("sb_1",     1'b1, 3'b000, 32'h0001_0001, 32'h0000_0055, 32'h0, 1'b0);
    txn("lw_sb",    1'b0, 3'b010, 32'h0001_0000, 32'h0,         32'hDEAD_55EF, 1'b0);
    txn("sh_2",     1'b1, 3'b001, 32'h0001_0002, 32'h0000_1234, 32'h0, 1'b0);
    txn("lw_sh",    1'b0, 3'b010, 32'h0001_0000, 32'h0,         32'h1234_55EF, 1'b0);

    // Top word of storage is legal
    txn("sw_top",   1'b1, 3'b010, 32'h0002_FFFC, 32'h0BAD_F00D, 32'h0, 1'b0);
    txn("lw_top",   1'b0, 3'b010, 32'h0002_FFFC, 32'h0,         32'h0BAD_F00D, 1'b0);

    // Errors
    txn("lw_misal", 1'b0, 3'b010, 32'h0001_0002, 32'h0,         32'h0, 1'b1);
    txn("lh_misal", 1'b0, 3'b001, 32'h0001_0001, 32'h0,         32'h0, 1'b1);
    txn("sw_below", 1'b1, 3'b010, 32'h0000_FFFC, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("lw_top2",  1'b0, 3'b010, 32'h0002_FFFC, 32'h0,         32'h0BAD_F00D, 1'b0);
    txn("ld_f3_011",1'b0, 3'b011, 32'h0001_0000, 32'h0,         32'h0, 1'b1);
    txn("st_f3_100",1'b1, 3'b100, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("lw_range", 1'b0, 3'b010, 32'h0003_0000, 32'h0,         32'h0, 1'b1);
    txn("lw_unchg", 1'b0, 3'b010, 32'h0001_0000, 32'h0,         32'h1234_55EF, 1'b0);

    // Backpressure: hold the response for 5 cycles
    send(1'b0, 3'b010, 32'h0001_0000, 32'h0);
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_rdata", o_rsp_rdata, 32'h1234_55EF);
      chk("bp_err", 32'(o_rsp_err), 32'd0);
      chk("bp_req_ready", 32'(o_req_ready), 32'd0);
      @(posedge clk); #1;
    end
    // A request offered during the response handshake edge must not be taken.
    d_valid = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 32'h0001_0000;
    ack();
    d_valid = 1'b0;
    chk("bp_rel_valid", 32'(o_rsp_valid), 32'd0);
    chk("bp_rel_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_idle_ready", 32'(o_req_ready), 32'd1);

    // Reset mid-transaction on the LATENCY=3 instance
    sel = 1'b1;
    txn("l3_sw_init", 1'b1, 3'b010, 32'h0001_0010, 32'h1122_3344, 32'h0, 1'b0);
    send(1'b1, 3'b010, 32'h0001_0010, 32'hCAFE_F00D);
    @(posedge clk); #1;
    rst3 = 1'b0;
    #1;
    chk("l3_rst_ready", 32'(o_req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("l3_rst_valid", 32'(o_rsp_valid), 32'd0);
    end
    rst3 = 1'b1;
    @(posedge clk); #1;
    chk("l3_no_rsp", 32'(o_rsp_valid), 32'd0);
    txn("l3_lw_prior", 1'b0, 3'b010, 32'h0001_0010, 32'h0, 32'h1122_3344, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
